// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared state type and grant encodings for the two-master bus arbiter
package bus_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT0, ARB_GRANT1} arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/bus_timeout_counter.sv
// rtl/bus_timeout_counter.sv - counts granted cycles without a slave ack and flags the last allowed one
module bus_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic Clk,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge Clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  // TIMEOUT of zero means a hung slave is waited on forever
  assign expired = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter sharing one slave bus between the CPU and host command masters
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  M0_cs,
  input  logic                  M0_we,
  input  logic [ADDR_WIDTH-1:0] M0_addr,
  input  logic [DATA_WIDTH-1:0] M0_wdata,
  output logic                  M0_ack,
  output logic                  M0_err,
  input  logic                  M1_cs,
  input  logic                  M1_we,
  input  logic [ADDR_WIDTH-1:0] M1_addr,
  input  logic [DATA_WIDTH-1:0] M1_wdata,
  output logic                  M1_ack,
  output logic                  M1_err,
  output logic [DATA_WIDTH-1:0] Rdata,
  output logic                  S_cs,
  output logic                  S_we,
  output logic [ADDR_WIDTH-1:0] S_addr,
  output logic [DATA_WIDTH-1:0] S_wdata,
  input  logic                  S_ack,
  input  logic [DATA_WIDTH-1:0] S_rdata,
  output logic [1:0]            Grant,
  output logic                  Busy
);

  arb_state_t state;
  logic       last_grant;
  logic       expired;
  logic       granted;

  assign granted = (state == ARB_GRANT0) || (state == ARB_GRANT1);

  bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .Clk     (Clk),
    .clr     (Rst || !granted),
    .en      (granted && !S_ack),
    .expired (expired)
  );

  // last_grant is 1 after reset so M0 wins the first tie
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= ARB_IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (M0_cs && (!M1_cs || last_grant)) begin
            state <= ARB_GRANT0;
          end else if (M1_cs) begin
            state <= ARB_GRANT1;
          end
        end
        ARB_GRANT0: begin
          if (!M0_cs || S_ack || expired) begin
            state      <= ARB_IDLE;
            last_grant <= 1'b0;
          end
        end
        ARB_GRANT1: begin
          if (!M1_cs || S_ack || expired) begin
            state      <= ARB_IDLE;
            last_grant <= 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // A real slave ack in the expiry cycle completes normally, so err needs !S_ack
  always_comb begin
    S_cs    = 1'b0;
    S_we    = 1'b0;
    S_addr  = '0;
    S_wdata = '0;
    Grant   = GRANT_NONE;
    M0_ack  = 1'b0;
    M0_err  = 1'b0;
    M1_ack  = 1'b0;
    M1_err  = 1'b0;
    case (state)
      ARB_GRANT0: begin
        Grant   = GRANT_M0;
        S_cs    = M0_cs;
        S_we    = M0_we;
        S_addr  = M0_addr;
        S_wdata = M0_wdata;
        M0_ack  = M0_cs && (S_ack || expired);
        M0_err  = M0_cs && !S_ack && expired;
      end
      ARB_GRANT1: begin
        Grant   = GRANT_M1;
        S_cs    = M1_cs;
        S_we    = M1_we;
        S_addr  = M1_addr;
        S_wdata = M1_wdata;
        M1_ack  = M1_cs && (S_ack || expired);
        M1_err  = M1_cs && !S_ack && expired;
      end
      default: ;
    endcase
  end

  assign Busy  = (Grant != GRANT_NONE);
  assign Rdata = S_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed and randomized checks of bus_arbiter against a transaction-level model
module tb_bus_arbiter;
  import bus_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          M0_cs, M0_we, M1_cs, M1_we;
  logic [AW-1:0] M0_addr, M1_addr;
  logic [DW-1:0] M0_wdata, M1_wdata;
  logic          M0_ack, M0_err, M1_ack, M1_err;
  logic [DW-1:0] Rdata, S_wdata, S_rdata;
  logic          S_cs, S_we, S_ack;
  logic [AW-1:0] S_addr;
  logic [1:0]    Grant;
  logic          Busy;

  int tests_run = 0;
  int tests_failed = 0;

  bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst),
    .M0_cs(M0_cs), .M0_we(M0_we), .M0_addr(M0_addr), .M0_wdata(M0_wdata),
    .M0_ack(M0_ack), .M0_err(M0_err),
    .M1_cs(M1_cs), .M1_we(M1_we), .M1_addr(M1_addr), .M1_wdata(M1_wdata),
    .M1_ack(M1_ack), .M1_err(M1_err),
    .Rdata(Rdata), .S_cs(S_cs), .S_we(S_we), .S_addr(S_addr), .S_wdata(S_wdata),
    .S_ack(S_ack), .S_rdata(S_rdata), .Grant(Grant), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    M0_cs = 0; M0_we = 0; M0_addr = '0; M0_wdata = '0;
    M1_cs = 0; M1_we = 0; M1_addr = '0; M1_wdata = '0;
    S_ack = 0; S_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    Rst = 1;
    tick();
    tick();
    Rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    Rst = 1; M0_cs = 1; M1_cs = 1; S_ack = 1; S_rdata = 32'hA5A5_0F0F;
    tick(); settle();
    tests_run++;
    if ({S_cs, S_we, S_addr, S_wdata, Grant, Busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_bus: got cs=%b grant=%b busy=%b addr=%h, expected all zero", S_cs, Grant, Busy, S_addr);
    end
    tests_run++;
    if ({M0_ack, M0_err, M1_ack, M1_err} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_acks: got %b expected 0000", {M0_ack, M0_err, M1_ack, M1_err});
    end
    tests_run++;
    if (Rdata !== 32'hA5A5_0F0F) begin
      tests_failed++;
      $display("FAIL reset_rdata: got %h expected a5a50f0f", Rdata);
    end
    Rst = 0;
    clear_inputs();
    tick();
  endtask

  task automatic test_single_write();
    M0_cs = 1; M0_we = 1; M0_addr = 8'h10; M0_wdata = 32'hDEADBEEF;
    settle();
    tests_run++;
    if ({S_cs, Grant} !== 3'b000) begin
      tests_failed++;
      $display("FAIL write_req_cycle: got cs=%b grant=%b expected 0/00", S_cs, Grant);
    end
    tick(); settle();
    tests_run++;
    if ({S_cs, S_we, S_addr, S_wdata, Grant, M0_ack} !== {1'b1, 1'b1, 8'h10, 32'hDEADBEEF, GRANT_M0, 1'b0}) begin
      tests_failed++;
      $display("FAIL write_bus: got cs=%b we=%b addr=%h data=%h grant=%b ack=%b expected 1 1 10 deadbeef 01 0",
               S_cs, S_we, S_addr, S_wdata, Grant, M0_ack);
    end
    tick(); settle();
    tests_run++;
    if (M0_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_wait: got M0_ack=%b expected 0", M0_ack);
    end
    tick(); S_ack = 1; settle();
    tests_run++;
    if ({M0_ack, M0_err, M1_ack} !== 3'b100) begin
      tests_failed++;
      $display("FAIL write_ack: got ack/err/m1ack=%b expected 100", {M0_ack, M0_err, M1_ack});
    end
    tick(); M0_cs = 0; S_ack = 0; settle();
    tests_run++;
    if ({Grant, Busy} !== 3'b000) begin
      tests_failed++;
      $display("FAIL write_release: got grant=%b busy=%b expected 00 0", Grant, Busy);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    M0_cs = 1; M0_we = 0; M0_addr = 8'h04;
    M1_cs = 1; M1_we = 0; M1_addr = 8'h08;
    settle();
    tick(); S_ack = 1; S_rdata = 32'h0000_1234; settle();
    tests_run++;
    if ({Grant, S_addr, M0_ack, M1_ack, Rdata} !== {GRANT_M0, 8'h04, 1'b1, 1'b0, 32'h0000_1234}) begin
      tests_failed++;
      $display("FAIL tie_first: got grant=%b addr=%h acks=%b%b rdata=%h expected 01 04 10 00001234",
               Grant, S_addr, M0_ack, M1_ack, Rdata);
    end
    tick(); M0_cs = 0; S_ack = 0; settle();
    tests_run++;
    if (Grant !== GRANT_NONE) begin
      tests_failed++;
      $display("FAIL tie_bubble: got grant=%b expected 00", Grant);
    end
    tick(); S_ack = 1; S_rdata = 32'h0000_5678; settle();
    tests_run++;
    if ({Grant, S_addr, M0_ack, M1_ack, Rdata} !== {GRANT_M1, 8'h08, 1'b0, 1'b1, 32'h0000_5678}) begin
      tests_failed++;
      $display("FAIL tie_second: got grant=%b addr=%h acks=%b%b rdata=%h expected 10 08 01 00005678",
               Grant, S_addr, M0_ack, M1_ack, Rdata);
    end
    tick(); M1_cs = 0; S_ack = 0;
    tick();
  endtask

  task automatic test_round_robin();
    int seen[$];
    int cyc = 0;
    M0_cs = 1; M1_cs = 1; M0_we = 0; M1_we = 0; S_ack = 1;
    while (seen.size() < 6 && cyc < 40) begin
      settle();
      if (M0_ack) seen.push_back(0);
      if (M1_ack) seen.push_back(1);
      tick();
      cyc++;
    end
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (i >= seen.size()) begin
        tests_failed++;
        $display("FAIL rr_grant%0d: got no transfer within 40 cycles expected M%0d", i, i % 2);
      end else if (seen[i] != i % 2) begin
        tests_failed++;
        $display("FAIL rr_grant%0d: got M%0d expected M%0d", i, seen[i], i % 2);
      end
    end
    M0_cs = 0; M1_cs = 0; S_ack = 0;
    tick();
  endtask

  task automatic test_timeout();
    M1_cs = 1; M1_we = 1; M1_addr = 8'h20; M1_wdata = 32'h1111_2222;
    settle();
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k == 2) begin
        M0_cs = 1; M0_we = 0; M0_addr = 8'h30;
      end
      settle();
      tests_run++;
      if (k < TO) begin
        if ({Grant, M1_ack, M1_err} !== {GRANT_M1, 2'b00}) begin
          tests_failed++;
          $display("FAIL timeout_wait%0d: got grant=%b ack=%b err=%b expected 10 0 0", k, Grant, M1_ack, M1_err);
        end
      end else if ({M1_ack, M1_err, S_cs, M0_ack} !== 4'b1110) begin
        tests_failed++;
        $display("FAIL timeout_fire: got ack/err/cs/m0ack=%b expected 1110", {M1_ack, M1_err, S_cs, M0_ack});
      end
    end
    tick(); M1_cs = 0; settle();
    tests_run++;
    if (Grant !== GRANT_NONE) begin
      tests_failed++;
      $display("FAIL timeout_idle: got grant=%b expected 00", Grant);
    end
    tick(); S_ack = 1; settle();
    tests_run++;
    if ({Grant, M0_ack, M0_err} !== {GRANT_M0, 2'b10}) begin
      tests_failed++;
      $display("FAIL timeout_next: got grant=%b ack=%b err=%b expected 01 1 0", Grant, M0_ack, M0_err);
    end
    tick(); M0_cs = 0; S_ack = 0;
    tick();
  endtask

  task automatic test_collision_abort();
    M1_cs = 1; M1_we = 0; M1_addr = 8'h50;
    settle();
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k == TO) S_ack = 1;
      settle();
    end
    tests_run++;
    if ({M1_ack, M1_err} !== 2'b10) begin
      tests_failed++;
      $display("FAIL collision: got ack=%b err=%b expected 1 0", M1_ack, M1_err);
    end
    tick(); M1_cs = 0; S_ack = 0;
    tick();
    M0_cs = 1; M1_cs = 1; settle();
    tick(); settle();
    tests_run++;
    if (Grant !== GRANT_M0) begin
      tests_failed++;
      $display("FAIL abort_grant: got grant=%b expected 01", Grant);
    end
    tick(); M0_cs = 0; settle();
    tests_run++;
    if ({M0_ack, M0_err, S_cs} !== 3'b000) begin
      tests_failed++;
      $display("FAIL abort_noack: got ack/err/cs=%b expected 000", {M0_ack, M0_err, S_cs});
    end
    tick(); settle();
    tests_run++;
    if (Grant !== GRANT_NONE) begin
      tests_failed++;
      $display("FAIL abort_idle: got grant=%b expected 00", Grant);
    end
    tick(); S_ack = 1; settle();
    tests_run++;
    if ({Grant, M1_ack} !== {GRANT_M1, 1'b1}) begin
      tests_failed++;
      $display("FAIL abort_next: got grant=%b ack=%b expected 10 1", Grant, M1_ack);
    end
    tick(); M1_cs = 0; S_ack = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    M0_cs = 1; M0_we = 1; M0_addr = 8'h40; M0_wdata = 32'h4040_4040;
    settle();
    tick(); S_ack = 1; settle();
    tick(); M0_cs = 0; S_ack = 0;
    tick(); M0_cs = 1; settle();
    tick(); settle();
    tests_run++;
    if ({Grant, S_cs} !== {GRANT_M0, 1'b1}) begin
      tests_failed++;
      $display("FAIL mid_granted: got grant=%b cs=%b expected 01 1", Grant, S_cs);
    end
    Rst = 1;
    tick(); settle();
    tests_run++;
    if ({S_cs, Grant, M0_ack, M0_err} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL mid_reset: got cs=%b grant=%b ack=%b err=%b expected 0 00 0 0", S_cs, Grant, M0_ack, M0_err);
    end
    Rst = 0; M1_cs = 1;
    tick(); settle();
    tests_run++;
    if (Grant !== GRANT_M0) begin
      tests_failed++;
      $display("FAIL mid_tie: got grant=%b expected 01", Grant);
    end
    M0_cs = 0; M1_cs = 0;
    tick();
    tick();
  endtask

  task automatic test_random();
    bit            req[2];
    logic          we[2];
    logic [AW-1:0] ad[2];
    logic [DW-1:0] wd[2];
    int            owner = 0;
    int            held = 0;
    int            prev = 2;
    logic [80:0]   got, exp_v;
    logic [1:0]    e_grant;
    logic          e_cs, e_we, e_a0, e_e0, e_a1, e_e1;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    do_reset();
    for (int m = 0; m < 2; m++) begin
      req[m] = 0; we[m] = 0; ad[m] = '0; wd[m] = '0;
    end
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req[m] && $urandom_range(0, 2) == 0) begin
          req[m] = 1; we[m] = 1'($urandom_range(0, 1));
          ad[m] = AW'($urandom); wd[m] = $urandom;
        end else if (req[m] && $urandom_range(0, 15) == 0) begin
          req[m] = 0;
        end
      end
      M0_cs = req[0]; M0_we = we[0]; M0_addr = ad[0]; M0_wdata = wd[0];
      M1_cs = req[1]; M1_we = we[1]; M1_addr = ad[1]; M1_wdata = wd[1];
      S_ack = ($urandom_range(0, 3) == 0);
      S_rdata = $urandom;
      settle();
      e_grant = 2'b00; e_cs = 0; e_we = 0; e_addr = '0; e_wdata = '0;
      e_a0 = 0; e_e0 = 0; e_a1 = 0; e_e1 = 0;
      if (owner != 0) begin
        e_grant = (owner == 1) ? 2'b01 : 2'b10;
        e_cs = req[owner-1]; e_we = we[owner-1];
        e_addr = ad[owner-1]; e_wdata = wd[owner-1];
        if (owner == 1) begin
          e_a0 = req[0] && (S_ack || held == TO - 1);
          e_e0 = req[0] && !S_ack && held == TO - 1;
        end else begin
          e_a1 = req[1] && (S_ack || held == TO - 1);
          e_e1 = req[1] && !S_ack && held == TO - 1;
        end
      end
      exp_v = {e_grant, owner != 0, e_cs, e_we, e_addr, e_wdata, e_a0, e_e0, e_a1, e_e1, S_rdata};
      got   = {Grant, Busy, S_cs, S_we, S_addr, S_wdata, M0_ack, M0_err, M1_ack, M1_err, Rdata};
      tests_run++;
      if (got !== exp_v) begin
        tests_failed++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, got, exp_v);
      end
      if (owner == 0) begin
        held = 0;
        if (req[0] && req[1]) owner = (prev == 1) ? 2 : 1;
        else if (req[0]) owner = 1;
        else if (req[1]) owner = 2;
      end else if (!req[owner-1] || S_ack || held == TO - 1) begin
        prev = owner;
        owner = 0;
      end else begin
        held++;
      end
      if (e_a0) req[0] = 0;
      if (e_a1) req[1] = 0;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, expected completion");
    $fatal(1);
  end

  initial begin
    Rst = 1;
    clear_inputs();
    tick();
    test_reset();
    test_single_write();
    test_simultaneous();
    test_round_robin();
    test_timeout();
    test_collision_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single register/memory slave bus (Cs/We/Addr/Wdata/Ack handshake) between two masters:
  - M0: CPU core load/store port.
  - M1: host request_decoder command path.
- Round-robin grant; a grant is held until the slave acks, the master aborts, or a timeout fires.
- The timeout guarantees a hung slave never blocks the host debug path.

Parameters:
- ADDR_WIDTH, `ADDR_SIZE, address width of master and slave buses.
- DATA_WIDTH, `WORD_SIZE, data width of Wdata/Rdata.
- TIMEOUT, 255, number of granted cycles without S_ack before an error-ack is issued; 0 disables the timeout.

Ports:
- Clk  in  1  clock
- Rst  in  1  synchronous active-high reset
- M0_cs  in  1  M0 request; held high until M0_ack
- M0_we  in  1  M0 write enable
- M0_addr  in  ADDR_WIDTH  M0 address
- M0_wdata  in  DATA_WIDTH  M0 write data
- M0_ack  out  1  M0 transfer complete (one cycle)
- M0_err  out  1  M0 transfer timed out; valid with M0_ack
- M1_cs, M1_we, M1_addr, M1_wdata, M1_ack, M1_err  same as M0, for M1
- Rdata  out  DATA_WIDTH  read data, broadcast to both masters
- S_cs  out  1  slave chip select
- S_we  out  1  slave write enable
- S_addr  out  ADDR_WIDTH  slave address
- S_wdata  out  DATA_WIDTH  slave write data
- S_ack  in  1  slave ack
- S_rdata  in  DATA_WIDTH  slave read data
- Grant  out  2  one-hot current owner; 00 when idle
- Busy  out  1  Grant != 00

Behaviour:
- FSM states: IDLE, GRANT0, GRANT1. The state is registered; all bus outputs are combinational from the state and the inputs.
- Reset: after the first rising Clk edge with Rst high:
  - state = IDLE, last_grant = 1 (M0 wins the first tie), timeout counter = 0.
  - Outputs: S_cs=0, S_we=0, S_addr=0, S_wdata=0, M*_ack=0, M*_err=0, Grant=00, Busy=0.
  - Reset mid-transfer drops S_cs with no ack to the master.
- Transitions from IDLE:
  - Only Mn_cs high -> GRANTn.
  - Both high -> GRANT of the master != last_grant.
  - Neither -> stay in IDLE.
- Output muxing:
  - In GRANTn: S_cs=Mn_cs; S_we/S_addr/S_wdata come from Mn.
  - Otherwise S_* = 0.
  - Rdata = S_rdata at all times.
- Ack routing:
  - Mn_ack = (state==GRANTn) & Mn_cs & S_ack.
  - The other master's ack is 0.
- Transitions from GRANTn:
  - S_ack & Mn_cs -> IDLE, last_grant<=n.
  - Mn_cs low with no ack (abort) -> IDLE, last_grant<=n, no ack issued.
  - Timeout (below) -> IDLE, last_grant<=n.
- Latency:
  - Request seen in cycle t; S_cs first high in t+1; earliest ack in t+1.
  - Mandatory one-cycle IDLE bubble between transfers, so a 1-cycle-ack slave sustains one transfer per 2 cycles.
- Timeout:
  - Counter clears on entry to GRANTn and increments each GRANTn cycle without S_ack.
  - When counter == TIMEOUT-1 and S_ack is low: Mn_ack=1 and Mn_err=1 for that cycle, and S_cs is still high that cycle.
  - Then return to IDLE.
  - S_ack and timeout in the same cycle: normal ack wins, Mn_err=0.
  - Counter width = $clog2(TIMEOUT+1).
  - With TIMEOUT=0, Mn_err is never asserted.
- Fairness:
  - A master that holds Mn_cs continuously cannot be granted twice in a row while the other requests.
  - Worst-case wait for a requester = one full transfer of the other master + 1 cycle.
- Masters must keep We/Addr/Wdata stable while Cs is high. The arbiter does not register them.
- S_ack seen in IDLE is ignored.

Decomposition:
- bus_arb_pkg holds:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT0, ARB_GRANT1} arb_state_t.
  - localparam GRANT_NONE=2'b00, GRANT_M0=2'b01, GRANT_M1=2'b10.
- One sub-module: bus_timeout_counter, with inputs clr, en and parameter TIMEOUT, and output expired.
- The FSM and muxing stay in bus_arbiter.

Test Plan:
- Single M0 write:
  - Stimulus: M0_cs=1, we=1, addr=8'h10, wdata=32'hDEADBEEF; slave acks 2 cycles after S_cs.
  - Required: S_cs high in t+1 with the same addr/data, M0_ack in t+3, M1_ack=0, Grant 01 -> 00.
- Simultaneous requests after reset:
  - Stimulus: M0 read 8'h04 and M1 read 8'h08 issued together; slave acks immediately with S_rdata=32'h0000_1234 then 32'h0000_5678.
  - Required: M0 served first, then M1 after a 1-cycle bubble; each master sees its own Rdata with its ack.
- Round-robin under continuous load:
  - Stimulus: both masters re-request immediately after each ack for 6 transfers.
  - Required: grant sequence M0, M1, M0, M1, M0, M1.
- Timeout:
  - Stimulus: TIMEOUT=4; M1 request, slave never acks.
  - Required: M1_ack=1 and M1_err=1 on the 4th granted cycle, then IDLE; a pending M0 request is granted next cycle.
- Ack/timeout collision and abort:
  - Stimulus: S_ack on exactly the 4th cycle with TIMEOUT=4.
  - Required: ack with err=0.
  - Stimulus: M0 drops Cs after 1 granted cycle.
  - Required: no ack, IDLE, M1 granted next.
- Reset mid-transfer:
  - Stimulus: Rst pulsed while in GRANT0 (with S_ack still low).
  - Required: after the edge S_cs=0, Grant=00, no M0_ack; the next tie goes to M0.
